// File: rtl/seg7_readback.sv
// Two-digit 7-segment readback monitor: synchronises both digits' segment lines,
// waits for the pattern to settle, decodes it to a hex byte and strobes value changes.
module seg7_readback #(
    parameter int STABLE_CYCLES = 250000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [6:0]  i_Segment1,
    input  logic [6:0]  i_Segment2,
    output logic [7:0]  o_Value,
    output logic        o_Valid,
    output logic        o_Error,
    output logic [15:0] o_Change_Count
);

    localparam int          CNT_W       = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SETTLE_LAST = STABLE_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    // Raw pin level that reads as "all segments off" for the selected polarity
    localparam logic [13:0] RAW_OFF     = ACTIVE_LOW ? 14'h3FFF : 14'h0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    // Returns {valid, nibble} for one logical {G..A} segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = 5'h10;
            7'h06:   res = 5'h11;
            7'h5B:   res = 5'h12;
            7'h4F:   res = 5'h13;
            7'h66:   res = 5'h14;
            7'h6D:   res = 5'h15;
            7'h7D:   res = 5'h16;
            7'h07:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h6F:   res = 5'h19;
            7'h77:   res = 5'h1A;
            7'h7C:   res = 5'h1B;
            7'h39:   res = 5'h1C;
            7'h5E:   res = 5'h1D;
            7'h79:   res = 5'h1E;
            7'h71:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [13:0]      sync1_r, sync2_r;
    logic [13:0]      pat_s;
    state_t           state_r, state_s;
    logic [13:0]      cand_r, cand_s;
    logic [13:0]      acc_r, acc_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       value_r, value_s;
    logic             valid_r, valid_s;
    logic             error_r, error_s;
    logic [15:0]      change_count_r, change_count_s;
    logic             seen_r, seen_s;
    logic [4:0]       dec_tens_s, dec_ones_s;
    logic             dec_ok_s;
    logic [7:0]       dec_val_s;
    logic             settle_done_s;

    // Two-flop synchroniser on all fourteen segment lines
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_r <= RAW_OFF;
            sync2_r <= RAW_OFF;
        end else begin
            sync1_r <= {i_Segment1, i_Segment2};
            sync2_r <= sync1_r;
        end
    end

    assign pat_s         = ACTIVE_LOW ? ~sync2_r : sync2_r;
    assign dec_tens_s    = seg_decode(cand_r[13:7]);
    assign dec_ones_s    = seg_decode(cand_r[6:0]);
    assign dec_ok_s      = dec_tens_s[4] & dec_ones_s[4];
    assign dec_val_s     = {dec_tens_s[3:0], dec_ones_s[3:0]};
    assign settle_done_s = (32'(cnt_r) + 32'd1) >= SETTLE_LAST;

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pat_s != acc_r) begin
                    state_s = S_SETTLE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (pat_s != cand_r) begin
                    state_s = S_SETTLE;
                end else if (settle_done_s) begin
                    state_s = S_DECODE;
                end else begin
                    state_s = S_SETTLE;
                end
            end
            S_DECODE: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // FSM output/datapath next values
    always_comb begin
        cand_s         = cand_r;
        acc_s          = acc_r;
        cnt_s          = cnt_r;
        value_s        = value_r;
        valid_s        = 1'b0;
        error_s        = error_r;
        change_count_s = change_count_r;
        seen_s         = seen_r;
        case (state_r)
            S_IDLE: begin
                if (pat_s != acc_r) begin
                    cand_s = pat_s;
                    cnt_s  = '0;
                end else begin
                    cand_s = cand_r;
                end
            end
            S_SETTLE: begin
                if (pat_s != cand_r) begin
                    cand_s = pat_s;
                    cnt_s  = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DECODE: begin
                acc_s = cand_r;
                if (dec_ok_s) begin
                    error_s = 1'b0;
                    // The very first valid decode pulses even if it reads 0x00
                    if ((dec_val_s != value_r) || !seen_r) begin
                        value_s = dec_val_s;
                        valid_s = 1'b1;
                        seen_s  = 1'b1;
                        if (change_count_r != 16'hFFFF) begin
                            change_count_s = change_count_r + 16'd1;
                        end else begin
                            change_count_s = change_count_r;
                        end
                    end else begin
                        valid_s = 1'b0;
                    end
                end else begin
                    error_s = 1'b1;
                end
            end
            default: begin
                cand_s = cand_r;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cand_r         <= 14'h0000;
            acc_r          <= 14'h0000;
            cnt_r          <= '0;
            value_r        <= 8'h00;
            valid_r        <= 1'b0;
            error_r        <= 1'b0;
            change_count_r <= 16'h0000;
            seen_r         <= 1'b0;
        end else begin
            cand_r         <= cand_s;
            acc_r          <= acc_s;
            cnt_r          <= cnt_s;
            value_r        <= value_s;
            valid_r        <= valid_s;
            error_r        <= error_s;
            change_count_r <= change_count_s;
            seen_r         <= seen_s;
        end
    end

    assign o_Value        = value_r;
    assign o_Valid        = valid_r;
    assign o_Error        = error_r;
    assign o_Change_Count = change_count_r;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: drives both polarities with the same logical
// patterns and compares against a transaction-level model of the readback behaviour.
module tb_seg7_readback;

    localparam int SC = 4;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg1_l, seg2_l, seg1_h, seg2_h;
    logic [7:0]  val_l, val_h;
    logic        vld_l, vld_h, err_l, err_h;
    logic [15:0] cnt_l, cnt_h;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // model state
    logic [13:0] m_acc;
    logic [7:0]  m_value;
    logic        m_err;
    logic [15:0] m_count;
    bit          m_first;
    logic [13:0] cur_pat;

    seg7_readback #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut_al (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Segment1(seg1_l), .i_Segment2(seg2_l),
        .o_Value(val_l), .o_Valid(vld_l), .o_Error(err_l), .o_Change_Count(cnt_l)
    );

    seg7_readback #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut_ah (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Segment1(seg1_h), .i_Segment2(seg2_h),
        .o_Value(val_h), .o_Valid(vld_h), .o_Error(err_h), .o_Change_Count(cnt_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lookup(input logic [6:0] s, output logic [3:0] nib);
        nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == s) begin
                nib = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_acc   = 14'h0000;
        m_value = 8'h00;
        m_err   = 1'b0;
        m_count = 16'h0000;
        m_first = 1'b0;
    endtask

    // A stable pattern that differs from the accepted one (or a settle forced by a glitch) is decoded
    task automatic predict(input logic [13:0] pat, input bit redo, output bit pulse);
        logic [3:0] t, o;
        bit ok_t, ok_o;
        pulse = 1'b0;
        if (pat == m_acc && !redo) return;
        m_acc = pat;
        ok_t = lookup(pat[13:7], t);
        ok_o = lookup(pat[6:0], o);
        if (ok_t && ok_o) begin
            m_err = 1'b0;
            if (!m_first || {t, o} != m_value) begin
                m_value = {t, o};
                m_first = 1'b1;
                pulse   = 1'b1;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic drive(input logic [13:0] pat);
        seg1_l  = ~pat[13:7];
        seg2_l  = ~pat[6:0];
        seg1_h  = pat[13:7];
        seg2_h  = pat[6:0];
        cur_pat = pat;
    endtask

    // Watches both instances for win cycles; counts pulses and their latency from the stimulus
    task automatic observe(input string tag, input bit exp_pulse, input int win);
        int np_l = 0, np_h = 0, lat_l = 0, lat_h = 0;
        for (int c = 1; c <= win; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (vld_l) begin
                np_l++;
                if (lat_l == 0) lat_l = c;
                check({tag, "/pval_l"}, 32'(val_l), 32'(m_value));
            end
            if (vld_h) begin
                np_h++;
                if (lat_h == 0) lat_h = c;
                check({tag, "/pval_h"}, 32'(val_h), 32'(m_value));
            end
        end
        check({tag, "/pulses_l"}, np_l, exp_pulse ? 32'd1 : 32'd0);
        check({tag, "/pulses_h"}, np_h, exp_pulse ? 32'd1 : 32'd0);
        if (exp_pulse) begin
            check({tag, "/lat_l"}, lat_l, SC + 3);
            check({tag, "/lat_h"}, lat_h, SC + 3);
        end
        check({tag, "/val_l"}, 32'(val_l), 32'(m_value));
        check({tag, "/val_h"}, 32'(val_h), 32'(m_value));
        check({tag, "/err_l"}, 32'(err_l), 32'(m_err));
        check({tag, "/err_h"}, 32'(err_h), 32'(m_err));
        check({tag, "/cnt_l"}, 32'(cnt_l), 32'(m_count));
        check({tag, "/cnt_h"}, 32'(cnt_h), 32'(m_count));
    endtask

    task automatic step(input string tag, input logic [13:0] pat);
        bit p;
        predict(pat, 1'b0, p);
        drive(pat);
        observe(tag, p, SC + 8);
    endtask

    task automatic glitch(input string tag, input logic [13:0] gpat, input int g);
        bit p;
        logic [13:0] base;
        base = cur_pat;
        if (gpat == base) gpat = gpat ^ 14'h0001;
        drive(gpat);
        repeat (g) @(negedge clk);
        drive(base);
        predict(base, 1'b1, p);
        observe(tag, p, 2 * SC + 8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/val_l"}, 32'(val_l), 32'd0);
        check({tag, "/vld_l"}, 32'(vld_l), 32'd0);
        check({tag, "/err_l"}, 32'(err_l), 32'd0);
        check({tag, "/cnt_l"}, 32'(cnt_l), 32'd0);
        check({tag, "/val_h"}, 32'(val_h), 32'd0);
        check({tag, "/vld_h"}, 32'(vld_h), 32'd0);
        check({tag, "/err_h"}, 32'(err_h), 32'd0);
        check({tag, "/cnt_h"}, 32'(cnt_h), 32'd0);
    endtask

    function automatic logic [6:0] rand_digit();
        if ($urandom_range(3) != 0) return seg_tab[$urandom_range(15)];
        return 7'($urandom);
    endfunction

    initial begin
        bit p;
        rst_n = 1'b0;
        drive(14'h0000);
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("idle");

        step("v02", {7'h3F, 7'h5B});
        glitch("glitch1", {7'h3F, 7'h06}, 3);
        step("v99a", {7'h6F, 7'h6F});
        step("v00", {7'h3F, 7'h3F});
        step("v99b", {7'h6F, 7'h6F});
        check("cnt_after_3", 32'(cnt_l), 32'd4);
        step("blank", {7'h3F, 7'h00});
        step("v01", {7'h3F, 7'h06});

        // asynchronous reset two cycles into the settle of a new pattern
        drive({7'h4F, 7'h6D});
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        model_reset();
        predict(cur_pat, 1'b0, p);
        observe("after_rst", p, SC + 8);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(9);
            if (r < 2) begin
                glitch("rnd_glitch", {rand_digit(), rand_digit()}, $urandom_range(SC - 1, 1));
            end else if (r == 2) begin
                step("rnd_same", cur_pat);
            end else begin
                step("rnd", {rand_digit(), rand_digit()});
            end
        end

        step("v8F", {7'h7F, 7'h71});

        @(negedge clk);
        force dut_al.change_count_r = 16'hFFFE;
        force dut_ah.change_count_r = 16'hFFFE;
        #1;
        release dut_al.change_count_r;
        release dut_ah.change_count_r;
        m_count = 16'hFFFE;
        step("sat1", {7'h3F, 7'h06});
        step("sat2", {7'h06, 7'h06});
        check("sat_final", 32'(cnt_h), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Reader for the two-digit 7-segment display path: monitors both digits' segment lines and recovers the displayed hex byte.
- Synchronises the segment lines, waits for a pattern to stay stable, decodes it, and reports value changes with a one-cycle strobe.
- Used as a loopback/self-check monitor beside the Binary_To_7Segment display path, and as a front end for segment-driven test fixtures.

Parameters:
- STABLE_CYCLES, 250000, cycles a synced pattern must hold unchanged before decode (10 ms at 25 MHz); legal range >= 1.
- ACTIVE_LOW, 1, 1 = a segment is lit when its input is 0 (board polarity); 0 = lit when its input is 1.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Segment1  in  7  tens digit, bit order {G,F,E,D,C,B,A}, raw pin polarity
- i_Segment2  in  7  ones digit, same bit order
- o_Value  out  8  last decoded value, {tens nibble, ones nibble}
- o_Valid  out  1  one-cycle pulse when o_Value is updated
- o_Error  out  1  level; the last stable pattern was undecodable
- o_Change_Count  out  16  number of o_Valid pulses since reset, saturating

Behaviour:
- Reset: one clock; reset is asynchronous and active-low: i_Clk, i_Rst_L.
  - Asserting i_Rst_L low clears immediately: o_Value=0x00, o_Valid=0, o_Error=0, o_Change_Count=0, FSM=S_IDLE, stable counter=0.
  - Sync flops and the accepted pattern reset to logical all-off (14'h0000), so the first lit pattern after reset triggers a settle.
  - Reset mid-settle or mid-decode abandons the operation; no o_Valid pulse is produced.
- Input path:
  - 2-flop synchroniser on all 14 bits.
  - Normalise to lit=1 (invert when ACTIVE_LOW=1).
  - The 14-bit logical pattern is P.
- Decode table (logical {G..A} -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - Any other pattern, including blank 00, is invalid.
- Stable counter width: $clog2(STABLE_CYCLES+1).
- S_IDLE:
  - If P != accepted pattern: capture P as the candidate, clear the counter, go to S_SETTLE.
- S_SETTLE:
  - If P != candidate: recapture the candidate, clear the counter, stay.
  - Otherwise increment the counter; on reaching STABLE_CYCLES-1, go to S_DECODE.
- S_DECODE (one cycle):
  - accepted pattern <= candidate.
  - Both digits valid, and (value != o_Value or first decode since reset): o_Value <= value, o_Valid=1 for that cycle, o_Error <= 0, o_Change_Count += 1 (holds at 0xFFFF).
  - Both digits valid and value == o_Value: o_Error <= 0, no pulse.
  - Either digit invalid: o_Error <= 1; o_Value, o_Valid and o_Change_Count unchanged.
  - Always returns to S_IDLE.
- Latency: input change at edge E0 -> o_Valid high in the cycle after edge E0+STABLE_CYCLES+2.
  - Total latency is STABLE_CYCLES+3 cycles; all outputs are registered.
- Glitches: any pattern held for fewer than STABLE_CYCLES synced cycles is never reported.
  - A glitch that returns to the accepted pattern still runs one settle, then decode produces no pulse.
- Simultaneous events: an input change during S_DECODE is seen in S_IDLE on the next cycle; nothing is lost.
- An invalid stable pattern raises o_Error once; o_Error stays high until the next valid decode.

Test Plan:
- STABLE_CYCLES=4, ACTIVE_LOW=1. Release reset, drive seg1=~3F, seg2=~5B -> o_Valid pulse exactly 7 cycles after the change, o_Value=0x02, o_Change_Count=1, o_Error=0.
- From 0x02, pulse seg2 to ~06 for 3 cycles, then return to ~5B -> no o_Valid; o_Value stays 0x02; o_Change_Count stays 1.
- Step the inputs through 0x99 (6F,6F), then 0x00 (3F,3F), then 0x99 again -> three pulses with o_Value 0x99, 0x00, 0x99; o_Change_Count=4.
- Drive seg2 to logical 0x00 (blank) -> o_Error=1 at latency 7, o_Value unchanged, no pulse; then drive seg2=~06 -> o_Error=0, o_Value=0x01 (tens digit still 0), o_Valid pulse.
- Assert i_Rst_L low asynchronously 2 cycles into S_SETTLE -> all outputs 0 immediately; after release with inputs held, the first pulse arrives 7 cycles after release.
- ACTIVE_LOW=0, inputs 7F/71 -> o_Value=0x8F. Force o_Change_Count to 0xFFFE, then make two more changes -> count saturates at 0xFFFF.
